// File: rtl/wordle_engine.sv
// Parametrised Wordle game core: letter entry, duplicate-aware green/yellow/gray scoring,
// win/lose detection and answer selection by index into an external word ROM.
module wordle_engine #(
  parameter int WORD_LEN    = 5,
  parameter int MAX_GUESSES = 6,
  parameter int NUM_WORDS   = 20
) (
  input  logic                               Clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               ack,
  input  logic                               letter_valid,
  input  logic [7:0]                         letter_in,
  input  logic                               backspace,
  input  logic                               submit,
  input  logic [8*WORD_LEN-1:0]              answer,
  output logic [$clog2(NUM_WORDS)-1:0]       word_idx,
  output logic [8*WORD_LEN-1:0]              guess_out,
  output logic [$clog2(WORD_LEN+1)-1:0]      letter_cnt,
  output logic [$clog2(MAX_GUESSES+1)-1:0]   guess_num,
  output logic [2*WORD_LEN-1:0]              score,
  output logic                               score_valid,
  output logic                               err_short,
  output logic                               busy,
  output logic                               win,
  output logic                               lose
);
  localparam int IW = $clog2(NUM_WORDS);
  localparam int CW = $clog2(WORD_LEN+1);
  localparam int GW = $clog2(MAX_GUESSES+1);
  localparam int LW = $clog2(WORD_LEN);
  localparam logic [CW-1:0] FULL     = CW'(WORD_LEN);
  localparam logic [GW-1:0] LAST_G   = GW'(MAX_GUESSES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS-1);

  typedef enum logic [2:0] {IDLE, LOAD, ENTRY, SCORE, REPORT, DONE} state_t;
  state_t state;

  // Letter arrays are indexed by position, 0 = first letter
  logic [WORD_LEN-1:0][7:0] gbuf, ans_r;
  logic [WORD_LEN-1:0][1:0] sc;
  logic [WORD_LEN-1:0]      used, green;
  logic [IW-1:0]            idx_cnt;
  logic [CW-1:0]            step;
  logic [LW-1:0]            cur, slot, prev_slot, yel_pos;
  logic                     yel_hit, letter_ok;

  for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_lane
    assign guess_out[8*(WORD_LEN-1-gi) +: 8] = gbuf[gi];
    assign green[gi] = (gbuf[gi] == ans_r[gi]);
  end

  assign score     = sc;
  assign busy      = (state == LOAD) || (state == SCORE);
  assign cur       = LW'(step - CW'(1));
  assign slot      = LW'(letter_cnt);
  assign prev_slot = LW'(letter_cnt - CW'(1));
  assign letter_ok = (letter_in >= 8'h41) && (letter_in <= 8'h5A);

  // Lowest-index answer letter not yet claimed by a green or an earlier yellow
  always_comb begin
    yel_hit = 1'b0;
    yel_pos = '0;
    for (int j = 0; j < WORD_LEN; j++)
      if (!yel_hit && !used[j] && ans_r[j] == gbuf[cur]) begin
        yel_hit = 1'b1;
        yel_pos = LW'(j);
      end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx_cnt     <= '0;
      word_idx    <= '0;
      gbuf        <= '0;
      ans_r       <= '0;
      sc          <= '0;
      used        <= '0;
      step        <= '0;
      letter_cnt  <= '0;
      guess_num   <= '0;
      score_valid <= 1'b0;
      err_short   <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      err_short <= 1'b0;
      if (state == IDLE || state == DONE)
        idx_cnt <= (idx_cnt == LAST_IDX) ? '0 : idx_cnt + IW'(1);
      case (state)
        IDLE: if (start) begin
          word_idx <= idx_cnt;
          state    <= LOAD;
        end
        LOAD: begin
          for (int i = 0; i < WORD_LEN; i++)
            ans_r[i] <= answer[8*(WORD_LEN-1-i) +: 8];
          gbuf       <= '0;
          letter_cnt <= '0;
          guess_num  <= '0;
          sc         <= '0;
          state      <= ENTRY;
        end
        ENTRY: begin
          if (submit) begin
            if (letter_cnt == FULL) begin
              step  <= '0;
              state <= SCORE;
            end else
              err_short <= 1'b1;
          end else if (backspace) begin
            if (letter_cnt != '0) begin
              gbuf[prev_slot] <= '0;
              letter_cnt      <= letter_cnt - CW'(1);
            end
          end else if (letter_valid && letter_ok && letter_cnt < FULL) begin
            gbuf[slot] <= letter_in;
            letter_cnt <= letter_cnt + CW'(1);
          end
        end
        SCORE: begin
          if (step == '0) begin
            for (int i = 0; i < WORD_LEN; i++)
              sc[i] <= {green[i], 1'b0};
            used <= green;
          end else if (!green[cur] && yel_hit) begin
            sc[cur]       <= 2'b01;
            used[yel_pos] <= 1'b1;
          end
          if (step == FULL) begin
            score_valid <= 1'b1;
            guess_num   <= guess_num + GW'(1);
            state       <= REPORT;
          end
          step <= step + CW'(1);
        end
        REPORT: if (ack) begin
          score_valid <= 1'b0;
          if (&green) begin
            win   <= 1'b1;
            state <= DONE;
          end else if (guess_num == LAST_G) begin
            lose  <= 1'b1;
            state <= DONE;
          end else begin
            gbuf       <= '0;
            letter_cnt <= '0;
            state      <= ENTRY;
          end
        end
        DONE: if (start) begin
          win      <= 1'b0;
          lose     <= 1'b0;
          word_idx <= idx_cnt;
          state    <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
